alu_md_top: RTL

Parametrised execute datapath: register file, operand-2 mux, single-cycle ALU and an iterative unsigned multiply/divide unit, all behind a valid/ready handshake. It replaces the single-cycle register-file/ALU top in the CPU. Single-cycle ALU ops complete on the accept edge. Multiply/divide ops stall the issuing stage via `ready_out` for a fixed, parameter-defined number of cycles, then write back.

---
 rtl/alu_md_if.sv | 25 ++
 rtl/alu_md_top.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_md_if.sv
// Issue-side bundle of the execute datapath: operation request, handshake and result views.
interface alu_md_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid_in;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] Instr;
  logic                  ALUsrc;
  logic [3:0]            ALUctrl;
  logic                  RegWrite;
  logic [DATA_WIDTH-1:0] ImmOp;
  logic                  EQ;
  logic [DATA_WIDTH-1:0] a0;
  logic                  md_done;

  modport master (
    output valid_in, Instr, ALUsrc, ALUctrl, RegWrite, ImmOp,
    input  ready_out, EQ, a0, md_done
  );

  modport slave (
    input  valid_in, Instr, ALUsrc, ALUctrl, RegWrite, ImmOp,
    output ready_out, EQ, a0, md_done
  );
endinterface

// File: rtl/alu_md_top.sv
// Execute datapath: register file, operand-2 mux, single-cycle ALU and an iterative
// unsigned multiply/divide unit that stalls issue for DATA_WIDTH+1 cycles.
module alu_md_top #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input logic   clk,
  input logic   rst_n,
  alu_md_if.slave bus
);
  localparam int unsigned Depth = 2 ** REG_ADDR_WIDTH;
  localparam int unsigned ShW   = $clog2(DATA_WIDTH);
  localparam int unsigned CntW  = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned InstW = (DATA_WIDTH < 32) ? 32 : DATA_WIDTH;
  localparam logic [CntW-1:0] LastIter = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     hi_q, hi_d;
  logic [DATA_WIDTH-1:0]     lo_q, lo_d;
  logic [DATA_WIDTH-1:0]     b_q, b_d;
  logic [1:0]                op_q, op_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      rw_q, rw_d;

  logic [DATA_WIDTH-1:0]     rf_q [Depth];
  logic [InstW-1:0]          instr_ext;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic [DATA_WIDTH-1:0]     op1, op2, alu_res;
  logic [ShW-1:0]            shamt;
  logic                      accept, is_md;
  logic                      wr_en;
  logic [REG_ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [DATA_WIDTH:0]       sum, rem_shift;
  logic                      unused_instr;

  // Narrow datapaths zero-extend Instr so fields above the top bit read as 0.
  assign instr_ext    = InstW'(bus.Instr);
  assign unused_instr = ^instr_ext;
  assign rs1          = instr_ext[15 +: REG_ADDR_WIDTH];
  assign rs2          = instr_ext[20 +: REG_ADDR_WIDTH];
  assign rd           = instr_ext[7 +: REG_ADDR_WIDTH];

  assign op1   = rf_q[rs1];
  assign op2   = bus.ALUsrc ? bus.ImmOp : rf_q[rs2];
  assign shamt = op2[ShW-1:0];

  assign bus.EQ        = (op1 == op2);
  assign bus.a0        = rf_q[10];
  assign bus.ready_out = (state_q == StIdle);
  assign bus.md_done   = (state_q == StDone);

  assign is_md  = (bus.ALUctrl[3:2] == 2'b11);
  assign accept = bus.valid_in && (state_q == StIdle);

  always_comb begin
    alu_res = '0;
    case (bus.ALUctrl)
      4'b0000: alu_res = op1 + op2;
      4'b0001: alu_res = op1 - op2;
      4'b0010: alu_res = op1 & op2;
      4'b0011: alu_res = op1 | op2;
      4'b0100: alu_res = op1 ^ op2;
      4'b0101: alu_res = DATA_WIDTH'($signed(op1) < $signed(op2));
      4'b0110: alu_res = op1 << shamt;
      4'b0111: alu_res = op1 >> shamt;
      4'b1000: alu_res = $signed(op1) >>> shamt;
      4'b1001: alu_res = DATA_WIDTH'(op1 < op2);
      default: alu_res = '0;
    endcase
  end

  // Single write port: DONE writeback and single-cycle accepts never coincide.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rd;
    wr_data = alu_res;
    if (state_q == StDone) begin
      wr_en   = rw_q;
      wr_addr = rd_q;
      wr_data = op_q[0] ? hi_q : lo_q;
    end else if (accept && !is_md) begin
      wr_en = bus.RegWrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) rf_q[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  // hi/lo hold {product} for multiply and {remainder, quotient} for divide.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rw_d      = rw_q;
    sum       = '0;
    rem_shift = '0;
    unique case (state_q)
      StIdle: begin
        if (accept && is_md) begin
          state_d = StRun;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = op1;
          b_d     = op2;
          op_d    = bus.ALUctrl[1:0];
          rd_d    = rd;
          rw_d    = bus.RegWrite;
        end
      end
      StRun: begin
        if (op_q[1]) begin
          rem_shift = {hi_q, lo_q[DATA_WIDTH-1]};
          if (rem_shift >= {1'b0, b_q}) begin
            hi_d = rem_shift[DATA_WIDTH-1:0] - b_q;
            lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
          end else begin
            hi_d = rem_shift[DATA_WIDTH-1:0];
            lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
          {hi_d, lo_d} = {sum, lo_q[DATA_WIDTH-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastIter) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
    end
  end
endmodule
